// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one SRAM controller between the memory stage (port 0) and a secondary requester (port 1).
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority with port 0 winning ties.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_en,
  input  logic              p0_wr_en,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_write_data,
  output logic              p0_ready,
  output logic [63:0]       p0_read_data,
  input  logic              p1_rd_en,
  input  logic              p1_wr_en,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_write_data,
  output logic              p1_ready,
  output logic [63:0]       p1_read_data,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_ready,
  input  logic [63:0]       mem_read_data,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r;
  logic   req0_s;
  logic   req1_s;
  logic   win_s;
  logic   win_wr_s;

`ifdef SRAM_ARB_RR_EN
  logic last_r;
`endif

  // Winner selection; a port with both enables high is treated as a write.
  always_comb begin
    req0_s = p0_rd_en | p0_wr_en;
    req1_s = p1_rd_en | p1_wr_en;
`ifdef SRAM_ARB_RR_EN
    if (req0_s && req1_s) begin
      win_s = ~last_r;
    end else if (req1_s) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`else
    if (req0_s) begin
      win_s = 1'b0;
    end else if (req1_s) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`endif
    if (win_s) begin
      win_wr_s = p1_wr_en;
    end else begin
      win_wr_s = p0_wr_en;
    end
  end

  // Arbiter FSM with all outputs registered; controller is driven only from latched state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      p0_ready       <= 1'b0;
      p1_ready       <= 1'b0;
      p0_read_data   <= 64'd0;
      p1_read_data   <= 64'd0;
      mem_rd_en      <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_address    <= {ADDR_W{1'b0}};
      mem_write_data <= {DATA_W{1'b0}};
      grant          <= 1'b0;
      busy           <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_r         <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_s || req1_s) begin
            state_r        <= BUSY;
            grant          <= win_s;
            busy           <= 1'b1;
            mem_wr_en      <= win_wr_s;
            mem_rd_en      <= ~win_wr_s;
            mem_address    <= win_s ? p1_address : p0_address;
            mem_write_data <= win_s ? p1_write_data : p0_write_data;
`ifdef SRAM_ARB_RR_EN
            last_r         <= win_s;
`endif
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state_r   <= DONE;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            if (grant) begin
              p1_ready     <= 1'b1;
              p1_read_data <= mem_read_data;
            end else begin
              p0_ready     <= 1'b1;
              p0_read_data <= mem_read_data;
            end
          end
        end
        DONE: begin
          state_r  <= IDLE;
          p0_ready <= 1'b0;
          p1_ready <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          p0_ready  <= 1'b0;
          p1_ready  <= 1'b0;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
